// File: rtl/addsub_seq_if.sv
// Handshake and data bundle for addsub_seq.
// The master side presents operands and accepts results. The slave side is the arithmetic block.
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s_out;
  logic             c_out;
  logic             ovf_out;
  logic             zero_out;

  modport master (
    output in_valid, a, b, c_in, mode, out_ready,
    input  in_ready, out_valid, s_out, c_out, ovf_out, zero_out
  );

  modport slave (
    input  in_valid, a, b, c_in, mode, out_ready,
    output in_ready, out_valid, s_out, c_out, ovf_out, zero_out
  );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: a multi-cycle adder/subtractor that processes CHUNK bits per clock.
// A result takes N = WIDTH/CHUNK cycles.
// Subtraction is performed as a + ~b + c_in. A c_in of 1 therefore means "no borrow in".
// Optional feature: define ADDSUB_SAT_EN to clamp s_out on signed overflow.
// When the macro is defined, c_out and ovf_out still report the raw flags.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst_n,
  addsub_seq_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] s_next;
  logic             last_chunk;
  logic             msb_cin;
  logic             ovf_next;

  // Add the lowest chunk of the shifted operands and merge the result into the top of the accumulator.
  always_comb begin
    chunk_sum  = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    chunk_ext  = WIDTH'(chunk_sum[CHUNK-1:0]);
    acc_next   = (acc >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
    last_chunk = (cnt == CW'(N - 1));
    // Each sum bit equals a ^ b ^ carry_in, so XOR-ing back recovers the carry into the MSB.
    msb_cin    = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ chunk_sum[CHUNK-1];
    ovf_next   = msb_cin ^ chunk_sum[CHUNK];
`ifdef ADDSUB_SAT_EN
    // On overflow, both operands share the sign of a. The true result has the opposite sign of the wrapped sum.
    s_next = ovf_next ? {a_sh[CHUNK-1], {(WIDTH-1){~a_sh[CHUNK-1]}}} : acc_next;
`else
    s_next = acc_next;
`endif
  end

  // Control FSM with datapath registers: accept, step through chunks, then hold the result until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      s_q         <= '0;
      c_q         <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh       <= bus.a;
            b_sh       <= bus.mode ? ~bus.b : bus.b;
            carry      <= bus.c_in;
            cnt        <= '0;
            acc        <= '0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          acc   <= acc_next;
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (last_chunk) begin
            s_q         <= s_next;
            c_q         <= chunk_sum[CHUNK];
            ovf_q       <= ovf_next;
            zero_q      <= (s_next == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s_out     = s_q;
  assign bus.c_out     = c_q;
  assign bus.ovf_out   = ovf_q;
  assign bus.zero_out  = zero_q;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH SHALL be a multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry in; for subtract, 1 = no borrow in.
REQ-010 mode  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 s_out  output  WIDTH  result.
REQ-014 c_out  output  1  carry out of MSB; for subtract, 1 = no borrow out.
REQ-015 ovf_out  output  1  two's-complement signed overflow.
REQ-016 zero_out  output  1  s_out equals zero.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 SHALL drive in_ready = 1 only in IDLE.
REQ-019 SHALL drive out_valid = 1 only in DONE.
REQ-020 In IDLE, in_valid && in_ready at an edge SHALL capture a, c_in, and (mode ? ~b : b), clear the chunk counter, and enter BUSY.
REQ-021 In BUSY, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) with the running carry, starting from the captured c_in, LSB chunk first.
REQ-022 SHALL leave BUSY after exactly N cycles; out_valid SHALL rise N cycles after the accepting edge.
REQ-023 When entering DONE, c_out SHALL be the final carry and ovf_out SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-024 In DONE, s_out, c_out, ovf_out and zero_out SHALL hold stable until out_valid && out_ready at an edge, which SHALL return the FSM to IDLE.
REQ-025 SHALL give a maximum throughput of one operation per N+2 cycles; there is no overlap between result hand-off and next accept.
REQ-026 SHALL ignore in_valid, a, b, c_in and mode outside IDLE.
REQ-027 Outputs SHALL retain their last values in IDLE and BUSY; only out_valid qualifies them.
REQ-028 zero_out SHALL be computed from the final s_out driven on the port.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and set s_out, c_out, ovf_out, zero_out, out_valid and all internal registers to 0.
REQ-030 Reset in BUSY or DONE SHALL abort the operation without producing a result.
REQ-031 The first accept SHALL be possible at the first rising edge with rst_n high.

Configuration
REQ-032 Macro ADDSUB_SAT_EN defined: when ovf_out = 1, s_out SHALL saturate to 0111..1 if the true result is positive, or 1000..0 if negative.
REQ-033 With ADDSUB_SAT_EN defined, c_out and ovf_out SHALL remain the raw, unsaturated flags.
REQ-034 Macro ADDSUB_SAT_EN undefined: s_out SHALL be the raw wrapped sum and no saturation logic SHALL be present.

Verification (WIDTH=16, CHUNK=4)
REQ-035 Add: a=0x1234, b=0x0FF1, c_in=0, mode=0 -> s_out=0x2225, c_out=0, ovf_out=0, zero_out=0, out_valid 4 cycles after accept.
REQ-036 Sub: a=0x0005, b=0x0007, c_in=1, mode=1 -> s_out=0xFFFE, c_out=0, ovf_out=0; equal operands 0x00AB - 0x00AB -> s_out=0x0000, zero_out=1, c_out=1.
REQ-037 Overflow: 0x7FFF+0x0001 (add, c_in=0) -> ovf_out=1, s_out=0x8000, or 0x7FFF with ADDSUB_SAT_EN; 0x8000-0x0001 (sub, c_in=1) -> ovf_out=1, s_out=0x7FFF, or 0x8000 with ADDSUB_SAT_EN.
REQ-038 Backpressure: out_ready held low 3 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-039 Reset mid-BUSY: rst_n pulsed low during chunk 2 -> all outputs 0 immediately, no out_valid; after release a new accept completes correctly.
